// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - parametrised LIFO stack with registered top-of-stack, occupancy and sticky error flags
module lifo_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PUSH,
    input  logic              POP,
    input  logic              CLR_ERR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] TOS,
    output logic [PTR_W-1:0]  SP,
    output logic [PTR_W:0]    COUNT,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVF,
    output logic              UDF
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO   = PTR_W'(2);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] tos_q;
    logic              ovf_q;
    logic              udf_q;

    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;
    logic              do_repl;
    logic              ovf_evt;
    logic              udf_evt;
    logic              mem_we;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  below_idx;
    logic [PTR_W-1:0]  wr_idx;

    assign full  = (count_q == CNT_DEPTH);
    assign empty = (count_q == '0);

    // Indices wrap modulo 2**PTR_W, which is exact because COUNT never exceeds DEPTH.
    assign top_idx   = count_q[PTR_W-1:0] - PTR_ONE;
    assign below_idx = count_q[PTR_W-1:0] - PTR_TWO;

    // PUSH+POP on an empty stack degenerates into a plain push.
    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        do_repl = 1'b0;
        ovf_evt = 1'b0;
        udf_evt = 1'b0;
        unique case ({PUSH, POP})
            2'b10: begin
                do_push = !full;
                ovf_evt = full;
            end
            2'b01: begin
                do_pop  = !empty;
                udf_evt = empty;
            end
            2'b11: begin
                do_push = empty;
                do_repl = !empty;
            end
            default: ;
        endcase
    end

    assign mem_we = do_push || do_repl;
    assign wr_idx = do_repl ? top_idx : count_q[PTR_W-1:0];

    // Storage carries no reset; stale entries are unreachable once COUNT is cleared.
    always_ff @(negedge Clk) begin
        if (mem_we) begin
            mem[wr_idx] <= DIN;
        end
    end

    always_ff @(negedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (do_push) begin
                count_q <= count_q + CNT_ONE;
                tos_q   <= DIN;
            end else if (do_repl) begin
                tos_q   <= DIN;
            end else if (do_pop) begin
                count_q <= count_q - CNT_ONE;
                tos_q   <= (count_q == CNT_ONE) ? '0 : mem[below_idx];
            end

            // A new error on the same edge as CLR_ERR keeps its flag set.
            if (CLR_ERR) begin
                ovf_q <= 1'b0;
                udf_q <= 1'b0;
            end
            if (ovf_evt) begin
                ovf_q <= 1'b1;
            end
            if (udf_evt) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign TOS   = tos_q;
    assign COUNT = count_q;
    assign SP    = empty ? '0 : top_idx;
    assign FULL  = full;
    assign EMPTY = empty;
    assign OVF   = ovf_q;
    assign UDF   = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed and randomized checks of lifo_stack at DEPTH=8/DATA_W=8 and DEPTH=5/DATA_W=16
module tb_lifo_stack;

    logic        Clk;
    logic        Rst;
    logic        PUSH;
    logic        POP;
    logic        CLR_ERR;
    logic [7:0]  din_a;
    logic [15:0] din_b;

    logic [7:0]  tos_a;
    logic [2:0]  sp_a;
    logic [3:0]  count_a;
    logic        full_a, empty_a, ovf_a, udf_a;

    logic [15:0] tos_b;
    logic [2:0]  sp_b;
    logic [3:0]  count_b;
    logic        full_b, empty_b, ovf_b, udf_b;

    int tests = 0;
    int fails = 0;

    // Reference: a plain array stack per instance plus sticky flags.
    int          mdep [2] = '{8, 5};
    int          mcnt [2];
    logic [15:0] mstk [2][8];
    bit          movf [2];
    bit          mudf [2];

    lifo_stack #(.DATA_W(8), .DEPTH(8)) dut_a (
        .Clk(Clk), .Rst(Rst), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR), .DIN(din_a),
        .TOS(tos_a), .SP(sp_a), .COUNT(count_a), .FULL(full_a), .EMPTY(empty_a),
        .OVF(ovf_a), .UDF(udf_a)
    );

    lifo_stack #(.DATA_W(16), .DEPTH(5)) dut_b (
        .Clk(Clk), .Rst(Rst), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR), .DIN(din_b),
        .TOS(tos_b), .SP(sp_b), .COUNT(count_b), .FULL(full_b), .EMPTY(empty_b),
        .OVF(ovf_b), .UDF(udf_b)
    );

    initial begin
        Clk = 1'b1;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input bit pu, input bit po, input bit cl, input logic [15:0] d);
        bit e;
        bit f;
        e = (mcnt[k] == 0);
        f = (mcnt[k] == mdep[k]);
        if (cl) begin
            movf[k] = 1'b0;
            mudf[k] = 1'b0;
        end
        if (pu && po) begin
            if (e) begin
                mstk[k][0] = d;
                mcnt[k] = 1;
            end else begin
                mstk[k][mcnt[k]-1] = d;
            end
        end else if (pu) begin
            if (f) movf[k] = 1'b1;
            else begin
                mstk[k][mcnt[k]] = d;
                mcnt[k]++;
            end
        end else if (po) begin
            if (e) mudf[k] = 1'b1;
            else mcnt[k]--;
        end
    endtask

    task automatic chk_model();
        logic [15:0] et;
        for (int k = 0; k < 2; k++) begin
            et = (mcnt[k] == 0) ? 16'h0 : mstk[k][mcnt[k]-1];
            if (k == 0) begin
                chk("a_tos", {24'h0, tos_a}, {16'h0, et});
                chk("a_count", {28'h0, count_a}, mcnt[k]);
                chk("a_sp", {29'h0, sp_a}, (mcnt[k] == 0) ? 0 : mcnt[k] - 1);
                chk("a_full", {31'h0, full_a}, {31'h0, mcnt[k] == mdep[k]});
                chk("a_empty", {31'h0, empty_a}, {31'h0, mcnt[k] == 0});
                chk("a_ovf", {31'h0, ovf_a}, {31'h0, movf[k]});
                chk("a_udf", {31'h0, udf_a}, {31'h0, mudf[k]});
            end else begin
                chk("b_tos", {16'h0, tos_b}, {16'h0, et});
                chk("b_count", {28'h0, count_b}, mcnt[k]);
                chk("b_sp", {29'h0, sp_b}, (mcnt[k] == 0) ? 0 : mcnt[k] - 1);
                chk("b_full", {31'h0, full_b}, {31'h0, mcnt[k] == mdep[k]});
                chk("b_empty", {31'h0, empty_b}, {31'h0, mcnt[k] == 0});
                chk("b_ovf", {31'h0, ovf_b}, {31'h0, movf[k]});
                chk("b_udf", {31'h0, udf_b}, {31'h0, mudf[k]});
            end
        end
    endtask

    // Drive between edges, let the falling edge act, then compare against the model.
    task automatic op(input bit pu, input bit po, input bit cl, input logic [15:0] d);
        @(posedge Clk);
        #1;
        PUSH    = pu;
        POP     = po;
        CLR_ERR = cl;
        din_a   = d[7:0];
        din_b   = d;
        @(negedge Clk);
        #1;
        model_step(0, pu, po, cl, {8'h00, d[7:0]});
        model_step(1, pu, po, cl, d);
        chk_model();
        PUSH    = 1'b0;
        POP     = 1'b0;
        CLR_ERR = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        PUSH = 1'b0;
        POP = 1'b0;
        CLR_ERR = 1'b0;
        din_a = 8'h0;
        din_b = 16'h0;
        model_reset();
        #2;
        chk_model();
        Rst = 1'b0;

        // Basic push then pop order
        op(1, 0, 0, 16'h0111);
        op(1, 0, 0, 16'h0222);
        op(1, 0, 0, 16'h0333);
        chk("t1_count", {28'h0, count_a}, 32'd3);
        chk("t1_sp", {29'h0, sp_a}, 32'd2);
        chk("t1_tos", {24'h0, tos_a}, 32'h33);
        chk("t1_empty", {31'h0, empty_a}, 32'd0);
        op(0, 1, 0, 16'h0);
        chk("t1_pop1", {24'h0, tos_a}, 32'h22);
        op(0, 1, 0, 16'h0);
        chk("t1_pop2", {24'h0, tos_a}, 32'h11);
        op(0, 1, 0, 16'h0);
        chk("t1_pop3", {24'h0, tos_a}, 32'h0);
        chk("t1_empty_end", {31'h0, empty_a}, 32'd1);

        // Fill to FULL and overflow; DEPTH=5 instance overflows earlier
        for (int i = 0; i < 8; i++) begin
            op(1, 0, 0, 16'hC000 | 16'(i + 1));
            if (i == 4) chk("t2_b_full", {31'h0, full_b}, 32'd1);
        end
        chk("t2_full", {31'h0, full_a}, 32'd1);
        chk("t2_b_ovf", {31'h0, ovf_b}, 32'd1);
        op(1, 0, 0, 16'h00AA);
        chk("t2_ovf_count", {28'h0, count_a}, 32'd8);
        chk("t2_ovf_tos", {24'h0, tos_a}, 32'h08);
        chk("t2_ovf", {31'h0, ovf_a}, 32'd1);
        op(0, 1, 0, 16'h0);
        chk("t2_pop_full", {31'h0, full_a}, 32'd0);
        chk("t2_pop_ovf", {31'h0, ovf_a}, 32'd1);
        op(0, 0, 1, 16'h0);
        chk("t2_clr_ovf", {31'h0, ovf_a}, 32'd0);
        for (int i = 0; i < 7; i++) op(0, 1, 0, 16'h0);
        op(0, 0, 1, 16'h0);

        // Underflow, then PUSH+POP on empty acts as push
        op(0, 1, 0, 16'h0);
        chk("t3_udf", {31'h0, udf_a}, 32'd1);
        chk("t3_count", {28'h0, count_a}, 32'd0);
        chk("t3_tos", {24'h0, tos_a}, 32'h0);
        op(1, 1, 0, 16'h005C);
        chk("t3_pp_count", {28'h0, count_a}, 32'd1);
        chk("t3_pp_tos", {24'h0, tos_a}, 32'h5C);
        chk("t3_pp_udf", {31'h0, udf_a}, 32'd1);

        // Replace top, including while FULL
        op(0, 1, 1, 16'h0);
        op(1, 0, 0, 16'h0011);
        op(1, 0, 0, 16'h0022);
        op(1, 0, 0, 16'h0033);
        op(1, 1, 0, 16'h0077);
        chk("t4_repl_count", {28'h0, count_a}, 32'd3);
        chk("t4_repl_tos", {24'h0, tos_a}, 32'h77);
        op(0, 1, 0, 16'h0);
        chk("t4_repl_pop", {24'h0, tos_a}, 32'h22);
        op(0, 0, 1, 16'h0);
        for (int i = 0; i < 6; i++) op(1, 0, 0, 16'h0040 | 16'(i));
        op(1, 1, 0, 16'h0099);
        chk("t4_full_repl_tos", {24'h0, tos_a}, 32'h99);
        chk("t4_full_repl_ovf", {31'h0, ovf_a}, 32'd0);

        // Asynchronous reset between edges
        op(0, 0, 1, 16'h0);
        op(1, 0, 0, 16'h0044);
        op(1, 0, 0, 16'h0044);
        #2;
        Rst = 1'b1;
        #1;
        chk("t5_rst_tos", {24'h0, tos_a}, 32'h0);
        chk("t5_rst_count", {28'h0, count_a}, 32'd0);
        chk("t5_rst_empty", {31'h0, empty_a}, 32'd1);
        chk("t5_rst_full", {31'h0, full_a}, 32'd0);
        model_reset();
        chk_model();
        #1;
        Rst = 1'b0;
        op(0, 1, 0, 16'h0);
        chk("t5_udf", {31'h0, udf_a}, 32'd1);

        // CLR_ERR racing a new underflow
        op(0, 0, 1, 16'h0);
        for (int i = 0; i < 9; i++) op(1, 0, 0, 16'h0060 | 16'(i));
        chk("t6_ovf_pre", {31'h0, ovf_a}, 32'd1);
        for (int i = 0; i < 8; i++) op(0, 1, 0, 16'h0);
        op(0, 1, 1, 16'h0);
        chk("t6_udf_wins", {31'h0, udf_a}, 32'd1);
        chk("t6_ovf_clr", {31'h0, ovf_a}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            bit cl;
            r  = $urandom_range(0, 9);
            cl = ($urandom_range(0, 15) == 0);
            if (r < 4)      op(1, 0, cl, 16'($urandom));
            else if (r < 7) op(0, 1, cl, 16'($urandom));
            else if (r < 9) op(1, 1, cl, 16'($urandom));
            else            op(0, 0, cl, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
